// File: rtl/mem_pkg.sv
// Shared definitions for the synchronous data memory: access-size codes,
// FSM state encoding and the store lane helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Little-endian byte-lane enables for a store of the given size at the given offset.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 4'b0001 << offset;
            SZ_HALF: return 4'b0011 << offset;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-justified store data across lanes so any enabled lane sees the right bytes.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: moves the addressed lane(s) of a raw memory word down to
// bit 0 and sign- or zero-extends to 32 bits. Purely combinational.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Shift the selected lane to bit 0, then extend according to size and signedness.
    always_comb begin
        shifted = raw >> {offset, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        data    = 32'h0;
        case (size)
            SZ_BYTE: data = sign_ext ? {{24{byte_s[7]}}, byte_s} : {24'h0, shifted[7:0]};
            SZ_HALF: data = sign_ext ? {{16{half_s[15]}}, half_s} : {16'h0, shifted[15:0]};
            SZ_WORD: data = shifted;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_sync.sv
// Clocked MIPS data memory with a valid/ready request port, byte/half/word
// access, post-reset clearing and a fixed-latency pipelined response path.
module data_memory_sync
    import mem_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state;
    logic [IDX_W-1:0] clr_cnt;

    logic             accept;
    logic             clearing;
    logic             out_of_range;
    logic             req_err;
    logic [IDX_W-1:0] mem_idx;
    logic [3:0]       mem_we;
    logic [31:0]      mem_wdata;

    logic [31:0]      mem [DEPTH];

    logic             vld_p0;
    logic             err_p0;
    logic             write_p0;
    logic [1:0]       size_p0;
    logic             sign_p0;
    logic [1:0]       offset_p0;
    logic [31:0]      raw_p0;
    logic [31:0]      load_p0;
    logic [31:0]      data_p0;

    logic             vld_out;
    logic             err_out;
    logic [31:0]      data_out;

    assign accept   = req_valid && req_ready;
    assign clearing = (state == ST_CLEAR);

    // Address bits above the storage range mark an out-of-range access;
    // when the array fills the whole address space nothing can be out of range.
    if (ADDR_WIDTH - 2 > IDX_W) begin : g_range
        assign out_of_range = |req_addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_full
        assign out_of_range = 1'b0;
    end

    // Classify the request: range, alignment and size-code errors.
    always_comb begin
        req_err = out_of_range;
        case (req_size)
            SZ_BYTE: req_err = out_of_range;
            SZ_HALF: if (req_addr[0]) req_err = 1'b1;
            SZ_WORD: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // Array port mux: the clear walker owns the port while clearing, requests otherwise.
    always_comb begin
        mem_idx   = req_addr[IDX_W+1:2];
        mem_we    = 4'h0;
        mem_wdata = lane_data(req_size, req_wdata);
        if (clearing) begin
            mem_idx   = clr_cnt;
            mem_we    = 4'hF;
            mem_wdata = 32'h0;
        end else if (accept && req_write && !req_err) begin
            mem_we    = lane_enables(req_size, req_addr[1:0]);
        end
    end

    // Clear/idle FSM; req_ready is registered and rises the cycle after the last word clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    req_ready <= 1'b0;
                    clr_cnt   <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Block RAM with per-byte write enables; the read port captures the old word at the accepting edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        if (accept) raw_p0 <= mem[mem_idx];
    end

    // ---- stage p0: request accepted, array read ----
    // Stage-0 valid bit; cleared by reset so nothing in flight survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p0 <= 1'b0;
        else        vld_p0 <= accept;
    end

    // Stage-0 request attributes needed to align and qualify the read word.
    always_ff @(posedge clk) begin
        if (accept) begin
            err_p0    <= req_err;
            write_p0  <= req_write;
            size_p0   <= req_size;
            sign_p0   <= req_signed;
            offset_p0 <= req_addr[1:0];
        end
    end

    mem_load_align u_align (
        .offset   (offset_p0),
        .size     (size_p0),
        .sign_ext (sign_p0),
        .raw      (raw_p0),
        .data     (load_p0)
    );

    assign data_p0 = (err_p0 || write_p0) ? 32'h0 : load_p0;

    // ---- stages p1..: plain delay of {valid, err, data} ----
    if (READ_LATENCY > 1) begin : g_pipe
        localparam int N = READ_LATENCY - 1;

        logic        vld_pn  [N];
        logic        err_pn  [N];
        logic [31:0] data_pn [N];

        // Delay-line valid bits, cleared by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) vld_pn[i] <= 1'b0;
            end else begin
                vld_pn[0] <= vld_p0;
                for (int i = 1; i < N; i++) vld_pn[i] <= vld_pn[i-1];
            end
        end

        // Delay-line payload; qualified by the valid bits so it needs no reset.
        always_ff @(posedge clk) begin
            err_pn[0]  <= err_p0;
            data_pn[0] <= data_p0;
            for (int i = 1; i < N; i++) begin
                err_pn[i]  <= err_pn[i-1];
                data_pn[i] <= data_pn[i-1];
            end
        end

        assign vld_out  = vld_pn[N-1];
        assign err_out  = err_pn[N-1];
        assign data_out = data_pn[N-1];
    end else begin : g_direct
        assign vld_out  = vld_p0;
        assign err_out  = err_p0;
        assign data_out = data_p0;
    end

    // Outputs are forced to zero whenever no response is being presented.
    assign resp_valid = vld_out;
    assign resp_err   = vld_out && err_out;
    assign resp_rdata = vld_out ? data_out : 32'h0;

endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync (DEPTH=256, READ_LATENCY=3, clear on reset).
module tb_data_memory_sync;
    import mem_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = 32;
    localparam int RL    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    data_memory_sync #(
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_resp = 0;
    int         run_len = 0;
    int         last_resp_cyc = -10;
    logic [7:0] bmem [DEPTH*4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: flat byte array, little-endian.
    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) bmem[i] = 8'h00;
    endtask

    function automatic logic model_err(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        if (sz == SZ_HALF && addr[0]) return 1'b1;
        if (sz == SZ_WORD && addr[1:0] != 2'b00) return 1'b1;
        if (addr[31:2] >= 30'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg);
        int a;
        logic [7:0]  b;
        logic [15:0] h;
        a = int'(addr[9:0]);
        b = bmem[a];
        if (sz == SZ_BYTE) return sg ? {{24{b[7]}}, b} : {24'h0, b};
        h = {bmem[a+1], bmem[a]};
        if (sz == SZ_HALF) return sg ? {{16{h[15]}}, h} : {16'h0, h};
        return {bmem[a+3], bmem[a+2], bmem[a+1], bmem[a]};
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        int a;
        a = int'(addr[9:0]);
        bmem[a] = wd[7:0];
        if (sz != SZ_BYTE) bmem[a+1] = wd[15:8];
        if (sz == SZ_WORD) begin
            bmem[a+2] = wd[23:16];
            bmem[a+3] = wd[31:24];
        end
    endtask

    // Drive one request from a negedge; it is accepted at the next posedge and its expectation queued.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] wd, input logic xerr, input logic [31:0] xdata, input string tag);
        exp_t e;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = sz;
        req_signed = sg;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        e.tag  = tag;
        e.err  = xerr;
        e.data = xdata;
        e.cyc  = cyc;
        exp_q.push_back(e);
        if (wr && !xerr) model_store(addr, sz, wd);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Request whose expectation comes from the reference model.
    task automatic op(input logic wr, input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] wd, input string tag);
        logic        xe;
        logic [31:0] xd;
        xe = model_err(addr, sz);
        xd = (wr || xe) ? 32'h0 : model_load(addr, sz, sg);
        send(wr, addr, sz, sg, wd, xe, xd, tag);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Called at the negedge where rst_n rises; counts cycles with req_ready low.
    task automatic measure_clear(output int n);
        n = 0;
        while (!req_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Response monitor: pops the scoreboard and checks error, data and latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid) begin
            n_resp++;
            if (cyc == last_resp_cyc + 1) run_len++;
            else                          run_len = 1;
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_resp", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq({e.tag, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
                check_eq({e.tag, "_data"}, resp_rdata, e.data);
                check_eq({e.tag, "_lat"}, 32'(cyc - e.cyc), 32'(RL - 1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nclr;
        int          resp_before;
        logic [31:0] a;
        logic [1:0]  sz;

        model_clear();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        check_eq("rst_resp_err", {31'h0, resp_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        measure_clear(nclr);
        check_eq("clear_cycles", 32'(nclr), 32'd256);

        // Cleared top word
        send(1'b0, 32'h3FC, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h0, "lw_3fc");

        // Byte/half/word stores and extending loads
        send(1'b1, 32'h10, SZ_WORD, 1'b0, 32'h11223344, 1'b0, 32'h0, "sw_10");
        send(1'b0, 32'h13, SZ_BYTE, 1'b1, 32'h0, 1'b0, 32'h00000011, "lb_13");
        send(1'b1, 32'h11, SZ_BYTE, 1'b0, 32'h00000080, 1'b0, 32'h0, "sb_11");
        send(1'b0, 32'h11, SZ_BYTE, 1'b1, 32'h0, 1'b0, 32'hFFFFFF80, "lb_11");
        send(1'b0, 32'h11, SZ_BYTE, 1'b0, 32'h0, 1'b0, 32'h00000080, "lbu_11");
        send(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h11228044, "lw_10");
        send(1'b0, 32'h10, SZ_HALF, 1'b1, 32'h0, 1'b0, 32'hFFFF8044, "lh_10");
        send(1'b0, 32'h12, SZ_HALF, 1'b0, 32'h0, 1'b0, 32'h00001122, "lhu_12");

        // Error cases leave memory alone
        send(1'b0, 32'h11, SZ_HALF, 1'b1, 32'h0, 1'b1, 32'h0, "lh_11_mis");
        send(1'b1, 32'h402, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0, "sw_402");
        send(1'b1, 32'h400, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0, "sw_400_oor");
        send(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h11228044, "lw_10_kept");
        send(1'b0, 32'h0, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h0, "lw_0_kept");

        // Store followed by load of the same word on the next cycle
        send(1'b1, 32'h20, SZ_WORD, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0, "sw_20");
        send(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, "lw_20");
        drain();

        // Illegal size code
        send(1'b1, 32'h20, 2'b11, 1'b0, 32'h12345678, 1'b1, 32'h0, "st_sz3");
        send(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, "lw_20_kept");
        drain();

        // Random mixed stores then a back-to-back load burst
        for (int i = 0; i < 12; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = {22'h0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(0, 3))};
            if (sz == SZ_HALF) a[0] = 1'b0;
            if (sz == SZ_WORD) a[1:0] = 2'b00;
            op(1'b1, a, sz, 1'b0, $urandom, "rnd_st");
        end
        drain();
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            a = {22'h0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(0, 3))};
            sz = 2'($urandom_range(0, 2));
            if (sz == SZ_HALF) a[0] = 1'b0;
            if (sz == SZ_WORD) a[1:0] = 2'b00;
            op(1'b0, a, sz, 1'($urandom_range(0, 1)), 32'h0, "burst_ld");
        end
        drain();
        check_eq("burst_run_len", 32'(run_len), 32'd10);

        // Reset with two loads in flight, then reset again mid-clear
        send(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, "fl_ld0");
        send(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h11228044, "fl_ld1");
        resp_before = n_resp;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("inflight_rst_valid", {31'h0, resp_valid}, 32'h0);
        check_eq("inflight_rst_ready", {31'h0, req_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check_eq("midclear_ready", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        measure_clear(nclr);
        check_eq("reclear_cycles", 32'(nclr), 32'd256);
        check_eq("no_late_resp", 32'(n_resp), 32'(resp_before));
        model_clear();
        send(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h0, "lw_20_cleared");
        send(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, 1'b0, 32'h0, "lw_10_cleared");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
